// File: rtl/la_iocfg.sv
// IO ring configuration loader: collects N pad bytes into shadow registers, then commits them all at once.
// Optional parity byte checking is enabled with the LA_IOCFG_PARITY_EN macro.
module la_iocfg #(
   parameter int N  = 8,
   parameter int CW = 8
) (
   input  logic            clk,
   input  logic            nreset,
   input  logic            start,
   input  logic            abort,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [CW-1:0]   in_data,
   output logic            busy,
   output logic            done,
   output logic            err,
   output logic [N*CW-1:0] ioring
);

   localparam int CNTW = $clog2(N + 2);

   typedef enum logic [1:0] {IDLE, LOAD, CHECK, COMMIT} state_t;

   state_t          state;
   state_t          state_next;
   logic [CNTW-1:0] cnt;
   logic [CW-1:0]   shadow [N];
   logic            accept;
   logic            last_beat;

   assign in_ready = (state == LOAD) && !abort;
   assign accept   = in_valid && in_ready;
   assign busy     = (state != IDLE);

`ifdef LA_IOCFG_PARITY_EN
   localparam logic [CNTW-1:0] PAR_BEAT = CNTW'(N);

   logic [CW-1:0] parity_byte;
   logic [CW-1:0] shadow_xor;
   logic          parity_ok;
   logic          err_q;

   // The parity byte follows the N data bytes as one extra beat.
   assign last_beat = (cnt == PAR_BEAT);

   always_comb begin
      shadow_xor = '0;
      for (int i = 0; i < N; i++) begin
         shadow_xor = shadow_xor ^ shadow[i];
      end
   end

   assign parity_ok = (parity_byte == shadow_xor);

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         parity_byte <= '0;
      end else if (accept && last_beat) begin
         parity_byte <= in_data;
      end
   end

   // Sticky error flag, cleared only by an accepted start.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         err_q <= 1'b0;
      end else if (state == IDLE && start) begin
         err_q <= 1'b0;
      end else if (state == CHECK && !abort && !parity_ok) begin
         err_q <= 1'b1;
      end
   end

   assign err = err_q;
`else
   localparam logic [CNTW-1:0] LAST_DATA = CNTW'(N - 1);

   assign last_beat = (cnt == LAST_DATA);
   assign err       = 1'b0;
`endif

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) state_next = LOAD;
         end
         LOAD: begin
            if (abort) begin
               state_next = IDLE;
            end else if (accept && last_beat) begin
`ifdef LA_IOCFG_PARITY_EN
               state_next = CHECK;
`else
               state_next = COMMIT;
`endif
            end
         end
         CHECK: begin
`ifdef LA_IOCFG_PARITY_EN
            // Abort wins over the comparison result.
            if (abort)          state_next = IDLE;
            else if (parity_ok) state_next = COMMIT;
            else                state_next = IDLE;
`else
            state_next = IDLE;
`endif
         end
         COMMIT: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         if (state == IDLE && start) begin
            cnt <= '0;
         end else if (accept) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   // Shadows only take data beats; the beat count doubles as the write index.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         for (int i = 0; i < N; i++) begin
            shadow[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            if (accept && cnt == CNTW'(i)) begin
               shadow[i] <= in_data;
            end
         end
      end
   end

   // All pads update in the same edge so none ever sees a partial load.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         ioring <= '0;
         done   <= 1'b0;
      end else begin
         done <= (state == COMMIT);
         if (state == COMMIT) begin
            for (int i = 0; i < N; i++) begin
               ioring[i*CW +: CW] <= shadow[i];
            end
         end
      end
   end

endmodule
